// File: rtl/fu_sequencer.sv
// fu_sequencer: command-driven operand sequencer for the 16-bit function unit.
// Owns an NREG x WIDTH register file. For each command it drives the operands
// and function select into the function unit, writes the result back to the
// register file and latches the V/C/N/Z flags into the status register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a command; LDI/RD/errors are resolved on accept
// EXEC  | operands presented to the function unit; writeback at exit
// RESP  | rsp_valid pulse for one cycle, then back to IDLE
module fu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [3:0]       cmd_fs,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_ra,
    input  logic [AW-1:0]    cmd_rb,
    input  logic [WIDTH-1:0] cmd_imm,
    output logic             rsp_valid,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [3:0]       fu_fs,
    input  logic [WIDTH-1:0] fu_result,
    input  logic             fu_v,
    input  logic             fu_c,
    input  logic             fu_n,
    input  logic             fu_z,
    output logic [3:0]       status
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] CMD_LDI = 2'b00;
    localparam logic [1:0] CMD_ALU = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;

    // Highest FunctionSelect code the function unit implements.
    localparam logic [3:0] FS_MAX = 4'b1100;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  regs [NREG];
    logic [AW-1:0]     rd_q;
    logic              err_q;
    logic              accept;
    logic              alu_ok;

    assign accept    = cmd_valid && cmd_ready;
    assign alu_ok    = (cmd_type == CMD_ALU) && (cmd_fs <= FS_MAX);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = rsp_valid && err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and ready decode.
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    state_next = alu_ok ? EXEC : RESP;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: command capture, operand drive, register file and status writeback.
    // The operands are captured at the accept edge, so fu_a/fu_b/fu_fs only change
    // when an ALU command starts and hold steady everywhere else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            rd_q     <= '0;
            err_q    <= 1'b0;
            rsp_data <= '0;
            fu_a     <= '0;
            fu_b     <= '0;
            fu_fs    <= '0;
            status   <= '0;
        end else if (accept) begin
            rd_q  <= cmd_rd;
            err_q <= 1'b0;
            case (cmd_type)
                CMD_LDI: begin
                    regs[cmd_rd] <= cmd_imm;
                    rsp_data     <= cmd_imm;
                end
                CMD_RD: begin
                    rsp_data <= regs[cmd_ra];
                end
                CMD_ALU: begin
                    if (alu_ok) begin
                        fu_a  <= regs[cmd_ra];
                        fu_b  <= regs[cmd_rb];
                        fu_fs <= cmd_fs;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                default: begin
                    err_q <= 1'b1;
                end
            endcase
        end else if (state == EXEC) begin
            regs[rd_q] <= fu_result;
            rsp_data   <= fu_result;
            status     <= {fu_v, fu_c, fu_n, fu_z};
        end
    end

endmodule

// File: tb/tb_fu_sequencer.sv
// Scoreboard bench for fu_sequencer with a behavioural function-unit model.
module tb_fu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = '0;
    logic [3:0]  cmd_fs = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_ra = '0;
    logic [2:0]  cmd_rb = '0;
    logic [15:0] cmd_imm = '0;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic [15:0] fu_a;
    logic [15:0] fu_b;
    logic [3:0]  fu_fs;
    logic [15:0] fu_result;
    logic        fu_v, fu_c, fu_n, fu_z;
    logic [3:0]  status;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [15:0] data;
        logic [3:0]  st;
        int          cyc;
    } exp_t;

    exp_t q[$];

    fu_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_fs(cmd_fs),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .fu_a(fu_a), .fu_b(fu_b), .fu_fs(fu_fs),
        .fu_result(fu_result),
        .fu_v(fu_v), .fu_c(fu_c), .fu_n(fu_n), .fu_z(fu_z),
        .status(status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Combinational function unit model.
    always_comb begin
        logic [15:0] x, y, r;
        logic [16:0] s;
        logic        cin, arith;
        x = fu_a; y = 16'h0000; cin = 1'b0; arith = 1'b1; r = 16'h0000; s = '0;
        case (fu_fs)
            4'd0:  y = 16'h0000;
            4'd1:  cin = 1'b1;
            4'd2:  y = fu_b;
            4'd3:  begin y = fu_b; cin = 1'b1; end
            4'd4:  y = ~fu_b;
            4'd5:  begin y = ~fu_b; cin = 1'b1; end
            4'd6:  y = 16'hFFFF;
            4'd7:  y = 16'h0000;
            default: arith = 1'b0;
        endcase
        if (arith) begin
            s = {1'b0, x} + {1'b0, y} + {16'h0000, cin};
            r = s[15:0];
            fu_c = s[16];
            fu_v = (x[15] == y[15]) && (r[15] != x[15]);
        end else begin
            case (fu_fs)
                4'd8:  r = fu_a & fu_b;
                4'd9:  r = fu_a | fu_b;
                4'd10: r = fu_a ^ fu_b;
                4'd11: r = ~fu_a;
                4'd12: r = fu_b;
                default: r = 16'h0000;
            endcase
            fu_c = 1'b0;
            fu_v = 1'b0;
        end
        fu_result = r;
        fu_n = r[15];
        fu_z = (r == 16'h0000);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare on every response pulse.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                if (!e.err) chk("rsp_data", {16'b0, rsp_data}, {16'b0, e.data});
                chk("status", {28'b0, status}, {28'b0, e.st});
                chk("latency", cyc, e.cyc);
                chk("ready_low_in_resp", {31'b0, cmd_ready}, 32'd0);
            end
        end
    end

    // Issue one command starting at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [1:0] t, input logic [3:0] fs, input logic [2:0] rd,
                         input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm,
                         input logic e_err, input logic [15:0] e_data, input logic [3:0] e_st,
                         input int lat, input bit keep);
        exp_t e;
        int waited;
        cmd_type = t; cmd_fs = fs; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
        cmd_valid = 1'b1;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 20 cycles");
            cmd_valid = 1'b0;
            return;
        end
        e.err = e_err; e.data = e_data; e.st = e_st; e.cyc = cyc + 1 + lat;
        q.push_back(e);
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_ready", {31'b0, cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
        chk("reset_rsp_data", {16'b0, rsp_data}, 32'd0);
        chk("reset_status", {28'b0, status}, 32'd0);
        chk("reset_fu_a", {16'b0, fu_a}, 32'd0);
        chk("reset_fu_b", {16'b0, fu_b}, 32'd0);
        chk("reset_fu_fs", {28'b0, fu_fs}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        //     type   fs     rd  ra  rb  imm       err  data      st       lat keep
        issue(2'b00, 4'h0, 1, 0, 0, 16'h7FFF, 0, 16'h7FFF, 4'b0000, 0, 0);
        issue(2'b00, 4'h0, 2, 0, 0, 16'h0001, 0, 16'h0001, 4'b0000, 0, 0);
        issue(2'b01, 4'h2, 3, 1, 2, 16'h0000, 0, 16'h8000, 4'b1010, 1, 0);
        issue(2'b10, 4'h0, 0, 3, 0, 16'h0000, 0, 16'h8000, 4'b1010, 0, 0);
        issue(2'b00, 4'h0, 4, 0, 0, 16'h0005, 0, 16'h0005, 4'b1010, 0, 0);
        issue(2'b01, 4'h5, 5, 4, 4, 16'h0000, 0, 16'h0000, 4'b0101, 1, 0);
        issue(2'b00, 4'h0, 6, 0, 0, 16'hFFFF, 0, 16'hFFFF, 4'b0101, 0, 0);
        issue(2'b01, 4'h1, 6, 6, 0, 16'h0000, 0, 16'h0000, 4'b0101, 1, 0);
        issue(2'b10, 4'h0, 0, 6, 0, 16'h0000, 0, 16'h0000, 4'b0101, 0, 0);
        // Illegal commands: no register or status change.
        issue(2'b01, 4'hE, 3, 1, 2, 16'h0000, 1, 16'h0000, 4'b0101, 0, 0);
        issue(2'b11, 4'h0, 3, 1, 2, 16'h1111, 1, 16'h0000, 4'b0101, 0, 0);
        issue(2'b10, 4'h0, 0, 3, 0, 16'h0000, 0, 16'h8000, 4'b0101, 0, 0);
        issue(2'b10, 4'h0, 0, 5, 0, 16'h0000, 0, 16'h0000, 4'b0101, 0, 0);
        // Back-to-back with cmd_valid held high.
        issue(2'b00, 4'h0, 0, 0, 0, 16'h1234, 0, 16'h1234, 4'b0101, 0, 1);
        issue(2'b01, 4'hA, 1, 0, 3, 16'h0000, 0, 16'h9234, 4'b0010, 1, 1);
        issue(2'b10, 4'h0, 0, 1, 0, 16'h0000, 0, 16'h9234, 4'b0010, 0, 1);
        issue(2'b01, 4'hB, 2, 1, 0, 16'h0000, 0, 16'h6DCB, 4'b0000, 1, 0);
        repeat (4) @(negedge clk);

        // Reset during EXEC of r7 = r1 + r2: abandoned, nothing written.
        cmd_type = 2'b01; cmd_fs = 4'h2; cmd_rd = 3'd7; cmd_ra = 3'd1; cmd_rb = 3'd2;
        cmd_valid = 1'b1;
        chk("pre_abort_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("exec_fu_a", {16'b0, fu_a}, 32'h9234);
        chk("exec_fu_b", {16'b0, fu_b}, 32'h6DCB);
        rst_n = 1'b0;
        #1;
        chk("abort_fu_a", {16'b0, fu_a}, 32'd0);
        chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
        chk("abort_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("abort_status", {28'b0, status}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b10, 4'h0, 0, 7, 0, 16'h0000, 0, 16'h0000, 4'b0000, 0, 0);
        issue(2'b10, 4'h0, 0, 1, 0, 16'h0000, 0, 16'h0000, 4'b0000, 0, 0);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
